// File: rtl/store_unit.sv
// Store path: formats GPR stores into byte-strobed word writes, queues them in order, and drains them to memory over req/ack.
// Optional misaligned/reserved-size dropping is enabled by defining STORE_MISALIGN_CHECK_EN.
module store_unit #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_data,
  input  logic [1:0]        in_size,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ack,
  output logic              busy,
  output logic              err
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic {IDLE, REQ} state_e;

  state_e            state_q;
  logic [PW:0]       wr_ptr_q, rd_ptr_q;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;

  logic [ADDR_W-1:0] addr_mem  [DEPTH];
  logic [31:0]       wdata_mem [DEPTH];
  logic [3:0]        wstrb_mem [DEPTH];

  logic [ADDR_W-1:0] fmt_addr;
  logic [31:0]       fmt_wdata;
  logic [3:0]        fmt_wstrb;
  logic              bad;
  logic              empty, full, push, enq, pop;

  always_comb begin
    fmt_addr  = {in_addr[ADDR_W-1:2], 2'b00};
    fmt_wdata = in_data;
    fmt_wstrb = 4'hF;
    case (in_size)
      2'd0: begin
        fmt_wdata = {4{in_data[7:0]}};
        fmt_wstrb = 4'b0001 << in_addr[1:0];
      end
      2'd1: begin
        fmt_wdata = {2{in_data[15:0]}};
        fmt_wstrb = 4'b0011 << {in_addr[1], 1'b0};
      end
      default: ;
    endcase
`ifdef STORE_MISALIGN_CHECK_EN
    bad = ((in_size == 2'd1) && in_addr[0]) ||
          ((in_size == 2'd2) && (in_addr[1:0] != 2'b00)) ||
          (in_size == 2'd3);
`else
    bad = 1'b0;
`endif
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign enq      = push && !bad;
  assign pop      = !empty && ((state_q == IDLE) || mem_ack);

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[wr_ptr_q[PW-1:0]]  <= fmt_addr;
      wdata_mem[wr_ptr_q[PW-1:0]] <= fmt_wdata;
      wstrb_mem[wr_ptr_q[PW-1:0]] <= fmt_wstrb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (pop) begin
        addr_q  <= addr_mem[rd_ptr_q[PW-1:0]];
        wdata_q <= wdata_mem[rd_ptr_q[PW-1:0]];
        wstrb_q <= wstrb_mem[rd_ptr_q[PW-1:0]];
      end
      case (state_q)
        IDLE: begin
          if (!empty) begin
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          // Ack with more queued keeps req high so writes go back to back.
          if (mem_ack && empty) begin
            req_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef STORE_MISALIGN_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= push && bad;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign mem_req   = req_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign busy      = !empty || (state_q == REQ);

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: formatting, queue fill/drain, push+pop wrap, misalignment, reset abort.
module tb_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [1:0]  in_size;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic        busy;
  logic        err;

  int ntests = 0;
  int nfail  = 0;

  logic [31:0] expq[$];
  int retired = 0;

  store_unit #(.ADDR_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .in_size(in_size),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Clock edge with scoreboard bookkeeping: retire on req&&ack, record accepts.
  task automatic tick;
    if (mem_req && mem_ack) begin
      if (expq.size() == 0) chk("sb_spurious_retire", 1'b1, 1'b0);
      else chk("sb_order", mem_wdata, expq.pop_front());
      retired++;
    end
    if (in_valid && in_ready) expq.push_back(in_data);
    step;
  endtask

  int acc;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0; in_size = 2'd0; mem_ack = 1'b0;
    step; step;
    chk("rst_req", mem_req, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_wstrb", mem_wstrb, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_err", err, 1'b0);
    rst_n = 1'b1;
    step;

    // Word store, ack after mem_req has been high for 3 cycles
    in_valid = 1'b1; in_addr = 32'h100; in_data = 32'hDEADBEEF; in_size = 2'd2;
    step;
    in_valid = 1'b0;
    chk("w_req_lat0", mem_req, 1'b0);
    chk("w_busy", busy, 1'b1);
    step;
    chk("w_req1", mem_req, 1'b1);
    chk("w_addr", mem_addr, 32'h100);
    chk("w_wdata", mem_wdata, 32'hDEADBEEF);
    chk("w_wstrb", mem_wstrb, 4'hF);
    step;
    chk("w_req2", mem_req, 1'b1);
    step;
    chk("w_req3", mem_req, 1'b1);
    chk("w_hold_addr", mem_addr, 32'h100);
    mem_ack = 1'b1;
    step;
    mem_ack = 1'b0;
    chk("w_req_done", mem_req, 1'b0);
    chk("w_busy_done", busy, 1'b0);

    // Byte at 0x103 then half at 0x102, back to back
    in_valid = 1'b1; in_addr = 32'h103; in_data = 32'h12345678; in_size = 2'd0;
    step;
    in_addr = 32'h102; in_data = 32'h0000AABB; in_size = 2'd1;
    step;
    in_valid = 1'b0;
    chk("b_req", mem_req, 1'b1);
    chk("b_addr", mem_addr, 32'h100);
    chk("b_wdata", mem_wdata, 32'h78787878);
    chk("b_wstrb", mem_wstrb, 4'b1000);
    mem_ack = 1'b1;
    step;
    chk("h_req", mem_req, 1'b1);
    chk("h_addr", mem_addr, 32'h100);
    chk("h_wdata", mem_wdata, 32'hAABBAABB);
    chk("h_wstrb", mem_wstrb, 4'b1100);
    step;
    mem_ack = 1'b0;
    chk("bh_req_done", mem_req, 1'b0);
    chk("bh_busy_done", busy, 1'b0);
    chk("bh_err", err, 1'b0);

    // Fill: one write in flight plus DEPTH queued, then in_ready drops
    acc = 0;
    in_valid = 1'b1; in_size = 2'd2;
    for (int i = 0; i < 6; i++) begin
      in_addr = 32'h200 + 32'(4 * i);
      in_data = 32'h1000 + 32'(i);
      if (in_ready) acc++;
      step;
    end
    in_valid = 1'b0;
    chk("fill_accepted", 32'(acc), 32'd5);
    chk("fill_ready_low", in_ready, 1'b0);
    chk("fill_head", mem_wdata, 32'h1000);
    mem_ack = 1'b1;
    for (int i = 1; i < 5; i++) begin
      step;
      chk("drain_req", mem_req, 1'b1);
      chk("drain_wdata", mem_wdata, 32'h1000 + 32'(i));
      chk("drain_addr", mem_addr, 32'h200 + 32'(4 * i));
      if (i == 1) chk("drain_ready", in_ready, 1'b1);
    end
    step;
    mem_ack = 1'b0;
    chk("drain_req_done", mem_req, 1'b0);
    chk("drain_busy", busy, 1'b0);

    // Steady push+pop with DEPTH-1 queued over 3*DEPTH stores
    expq.delete();
    retired = 0;
    in_valid = 1'b1; in_size = 2'd2; in_addr = 32'h300;
    for (int i = 0; i < 4; i++) begin
      in_data = 32'h5000 + 32'(i);
      tick;
    end
    chk("pp_ready_pre", in_ready, 1'b1);
    mem_ack = 1'b1;
    for (int i = 4; i < 16; i++) begin
      in_data = 32'h5000 + 32'(i);
      chk("pp_ready", in_ready, 1'b1);
      tick;
    end
    in_valid = 1'b0;
    chk("pp_retired_mid", 32'(retired), 32'd12);
    for (int i = 0; i < 10; i++) if (busy || mem_req) tick;
    mem_ack = 1'b0;
    chk("pp_retired_all", 32'(retired), 32'd16);
    chk("pp_sb_empty", 32'(expq.size()), 32'd0);
    chk("pp_busy", busy, 1'b0);

    // Misaligned word at 0x101
    in_valid = 1'b1; in_addr = 32'h101; in_data = 32'hCAFEF00D; in_size = 2'd2;
    step;
    in_valid = 1'b0;
`ifdef STORE_MISALIGN_CHECK_EN
    chk("mis_err_pulse", err, 1'b1);
    step;
    chk("mis_err_clear", err, 1'b0);
    chk("mis_no_req", mem_req, 1'b0);
    chk("mis_busy", busy, 1'b0);
`else
    chk("mis_err", err, 1'b0);
    step;
    chk("mis_req", mem_req, 1'b1);
    chk("mis_addr", mem_addr, 32'h100);
    chk("mis_wstrb", mem_wstrb, 4'hF);
    chk("mis_wdata", mem_wdata, 32'hCAFEF00D);
    mem_ack = 1'b1;
    step;
    mem_ack = 1'b0;
    chk("mis_done", mem_req, 1'b0);
`endif

    // Reset mid-REQ with 3 entries queued
    in_valid = 1'b1; in_size = 2'd2; in_addr = 32'h400;
    for (int i = 0; i < 4; i++) begin
      in_data = 32'h7000 + 32'(i);
      step;
    end
    in_valid = 1'b0;
    chk("ra_req_pre", mem_req, 1'b1);
    chk("ra_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("ra_req_drop", mem_req, 1'b0);
    chk("ra_busy", busy, 1'b0);
    chk("ra_ready", in_ready, 1'b1);
    step; step;
    rst_n = 1'b1;
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      chk("ra_no_stale_req", mem_req, 1'b0);
    end
    chk("ra_busy_post", busy, 1'b0);
    chk("ra_ready_post", in_ready, 1'b1);
    mem_ack = 1'b0;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
